// File: rtl/i2c_target_responder.sv
// I2C target that ACKs SLAVE_ADDR, hands write bytes to a local sink and fetches
// read bytes from a local source, stretching SCL until the source answers.
module i2c_target_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic [7:0] wr_data_o,
  output logic       wr_valid_o,
  output logic       rd_req_o,
  input  logic       rd_ack_i,
  input  logic [7:0] rd_data_i,
  output logic       nack_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ADDR       = 4'd1,
    ST_ADDR_ACK   = 4'd2,
    ST_WRITE_BYTE = 4'd3,
    ST_WRITE_ACK  = 4'd4,
    ST_READ_FETCH = 4'd5,
    ST_READ_BYTE  = 4'd6,
    ST_READ_ACK   = 4'd7,
    ST_IGNORE     = 4'd8
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic [3:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   rw;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] byte_in;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = ~sda_s & sda_d & scl_s;
  assign stop_det  = sda_s & ~sda_d & scl_s;
  assign byte_in   = {shreg[6:0], sda_s};
  assign state_o   = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      scl_o      <= 1'b1;
      sda_o      <= 1'b1;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
      wr_data_o  <= 8'h00;
      wr_valid_o <= 1'b0;
      rd_req_o   <= 1'b0;
      nack_o     <= 1'b0;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      rw         <= 1'b0;
    end else begin
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      wr_valid_o <= 1'b0;
      nack_o     <= 1'b0;
      if (start_det) begin
        start_o  <= 1'b1;
        busy_o   <= 1'b1;
        sda_o    <= 1'b1;
        scl_o    <= 1'b1;
        rd_req_o <= 1'b0;
        bit_cnt  <= 4'd0;
        state    <= ST_ADDR;
      end else if (stop_det) begin
        stop_o   <= 1'b1;
        busy_o   <= 1'b0;
        sda_o    <= 1'b1;
        scl_o    <= 1'b1;
        rd_req_o <= 1'b0;
        bit_cnt  <= 4'd0;
        state    <= ST_IDLE;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg <= byte_in;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd8;
              rw      <= byte_in[0];
              state   <= (byte_in[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          // Count 8 marks the low phase before the ACK bit, 9 the low phase after it.
          ST_ADDR_ACK, ST_WRITE_ACK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd9;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_o <= 1'b0;
              end else begin
                sda_o   <= 1'b1;
                bit_cnt <= 4'd0;
                if (state == ST_WRITE_ACK || !rw) begin
                  state <= ST_WRITE_BYTE;
                end else begin
                  rd_req_o <= 1'b1;
                  scl_o    <= 1'b0;
                  state    <= ST_READ_FETCH;
                end
              end
            end
          end
          ST_WRITE_BYTE: if (scl_rise) begin
            shreg <= byte_in;
            if (bit_cnt == 4'd7) begin
              wr_data_o  <= byte_in;
              wr_valid_o <= 1'b1;
              bit_cnt    <= 4'd8;
              state      <= ST_WRITE_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_READ_FETCH: if (rd_ack_i) begin
            shreg    <= rd_data_i;
            sda_o    <= rd_data_i[7];
            rd_req_o <= 1'b0;
            state    <= ST_READ_BYTE;
          end
          // SCL is let go one cycle after the MSB is on SDA.
          ST_READ_BYTE: begin
            if (!scl_o) scl_o <= 1'b1;
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_o <= 1'b1;
                state <= ST_READ_ACK;
              end else begin
                sda_o <= shreg[6];
                shreg <= {shreg[6:0], 1'b0};
              end
            end
          end
          ST_READ_ACK: begin
            if (scl_rise) begin
              bit_cnt <= 4'd9;
              if (sda_s) begin
                nack_o <= 1'b1;
                state  <= ST_IGNORE;
              end
            end else if (scl_fall && bit_cnt == 4'd9) begin
              bit_cnt  <= 4'd0;
              rd_req_o <= 1'b1;
              scl_o    <= 1'b0;
              state    <= ST_READ_FETCH;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a bit-level I2C master on a wired-AND bus,
// a delayed read-data source and a byte-level reference model.
module tb_i2c_target_responder;

  localparam logic [6:0] SLAVE_ADDR = 7'h22;
  localparam int H        = 8;
  localparam int RD_DELAY = 20;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       m_scl;
  logic       m_sda;
  logic       scl_o;
  logic       sda_o;
  logic       start_o;
  logic       stop_o;
  logic       busy_o;
  logic [7:0] wr_data_o;
  logic       wr_valid_o;
  logic       rd_req_o;
  logic       rd_ack_i;
  logic [7:0] rd_data_i;
  logic       nack_o;
  logic [3:0] state_o;
  logic       scl_bus;
  logic       sda_bus;

  assign scl_bus = m_scl & scl_o;
  assign sda_bus = m_sda & sda_o;

  always #5 clk = ~clk;

  i2c_target_responder #(.SLAVE_ADDR(SLAVE_ADDR), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o), .start_o(start_o), .stop_o(stop_o),
    .busy_o(busy_o), .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o),
    .rd_req_o(rd_req_o), .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i),
    .nack_o(nack_o), .state_o(state_o)
  );

  int checks = 0;
  int failures = 0;

  // Monitor counters, written only by the monitor.
  int start_cnt = 0, stop_cnt = 0, nack_cnt = 0, rd_req_rises = 0;
  int sda_low_cnt = 0, scl_run = 0, scl_low_max = 0;
  logic rd_req_q = 1'b0;
  logic [7:0] wr_got[$];

  always @(negedge clk) begin
    if (start_o) start_cnt++;
    if (stop_o) stop_cnt++;
    if (nack_o) nack_cnt++;
    if (wr_valid_o) wr_got.push_back(wr_data_o);
    if (rd_req_o && !rd_req_q) rd_req_rises++;
    rd_req_q = rd_req_o;
    if (!sda_o) sda_low_cnt++;
    if (!scl_o) begin
      scl_run++;
      if (scl_run > scl_low_max) scl_low_max = scl_run;
    end else begin
      scl_run = 0;
    end
  end

  // Read source: answers rd_req_o RD_DELAY cycles later with the next stored byte.
  logic [7:0] rd_mem[0:63];
  int rd_wr_idx = 0;
  int rd_rd_idx = 0;
  int rd_wait = 0;
  logic resp_en = 1'b1;

  initial begin
    rd_ack_i  = 1'b0;
    rd_data_i = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rd_req_o === 1'b1 && resp_en && !rd_ack_i) begin
        rd_wait++;
        if (rd_wait >= RD_DELAY) begin
          rd_ack_i  = 1'b1;
          rd_data_i = rd_mem[rd_rd_idx % 64];
          rd_rd_idx++;
        end
      end else begin
        rd_ack_i = 1'b0;
        rd_wait  = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scl_release_wait();
    int n;
    m_scl = 1'b1;
    n = 0;
    while (scl_bus !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("scl_release", {31'd0, scl_bus}, 32'd1);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    m_sda = b;
    tick(H);
    scl_release_wait();
    tick(H);
    r = sda_bus;
    m_scl = 1'b0;
    tick(2);
  endtask

  task automatic start_cond();
    m_sda = 1'b1;
    tick(H);
    scl_release_wait();
    tick(H);
    m_sda = 1'b0;
    tick(H);
    m_scl = 1'b0;
    tick(2);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0;
    tick(H);
    scl_release_wait();
    tick(H);
    m_sda = 1'b1;
    tick(H);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
    xfer_bit(1'b1, r);
    acked = ~r;
  endtask

  task automatic recv_byte(input logic ack_it, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      d[i] = r;
    end
    xfer_bit(~ack_it, r);
  endtask

  logic [7:0] exp_q[$];
  logic       ack;
  logic [7:0] d;
  int s_start, s_stop, s_nack, s_rdreq, s_sda, s_wr;

  task automatic snap();
    s_start = start_cnt; s_stop = stop_cnt; s_nack = nack_cnt;
    s_rdreq = rd_req_rises; s_sda = sda_low_cnt; s_wr = wr_got.size();
  endtask

  // Compare everything written since the last snap against the expected queue.
  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, wr_got.size() - s_wr, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (s_wr + i < wr_got.size()) chk({tag, "_wr_data"}, {24'd0, wr_got[s_wr + i]}, {24'd0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  initial begin
    rst_i = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(3);
    chk("rst_scl_o", {31'd0, scl_o}, 32'd1);
    chk("rst_sda_o", {31'd0, sda_o}, 32'd1);
    chk("rst_wr_data", {24'd0, wr_data_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rd_req", {31'd0, rd_req_o}, 32'd0);
    chk("rst_state", {28'd0, state_o}, 32'd0);
    rst_i = 1'b0;
    tick(5);

    // Matched write of two bytes.
    snap();
    start_cond();
    chk("t1_busy_mid", {31'd0, busy_o}, 32'd1);
    send_byte(8'h44, ack); chk("t1_addr_ack", {31'd0, ack}, 32'd1);
    send_byte(8'hA5, ack); chk("t1_d0_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h3C, ack); chk("t1_d1_ack", {31'd0, ack}, 32'd1);
    stop_cond();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    check_writes("t1");
    chk("t1_starts", start_cnt - s_start, 32'd1);
    chk("t1_stops", stop_cnt - s_stop, 32'd1);
    chk("t1_busy_end", {31'd0, busy_o}, 32'd0);

    // Foreign address: bus must never be driven.
    snap();
    start_cond();
    send_byte(8'h46, ack); chk("t2_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'hFF, ack); chk("t2_d0_ack", {31'd0, ack}, 32'd0);
    chk("t2_busy_mid", {31'd0, busy_o}, 32'd1);
    stop_cond();
    chk("t2_sda_untouched", sda_low_cnt - s_sda, 32'd0);
    check_writes("t2");
    chk("t2_busy_end", {31'd0, busy_o}, 32'd0);

    // Two-byte read with a slow source; master ACKs then NACKs.
    snap();
    rd_mem[rd_wr_idx % 64] = 8'h96; rd_wr_idx++;
    rd_mem[rd_wr_idx % 64] = 8'h0F; rd_wr_idx++;
    start_cond();
    send_byte(8'h45, ack); chk("t3_addr_ack", {31'd0, ack}, 32'd1);
    recv_byte(1'b1, d); chk("t3_rd0", {24'd0, d}, 32'h96);
    recv_byte(1'b0, d); chk("t3_rd1", {24'd0, d}, 32'h0F);
    stop_cond();
    tick(10);
    chk("t3_nack", nack_cnt - s_nack, 32'd1);
    chk("t3_rd_reqs", rd_req_rises - s_rdreq, 32'd2);
    chk("t3_stretch_ge20", {31'd0, (scl_low_max >= RD_DELAY)}, 32'd1);

    // Write then repeated START into a read.
    snap();
    rd_mem[rd_wr_idx % 64] = 8'h5D; rd_wr_idx++;
    start_cond();
    send_byte(8'h44, ack); chk("t4_addr_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h11, ack); chk("t4_d0_ack", {31'd0, ack}, 32'd1);
    start_cond();
    chk("t4_wr_data", {24'd0, wr_data_o}, 32'h11);
    send_byte(8'h45, ack); chk("t4_raddr_ack", {31'd0, ack}, 32'd1);
    tick(4);
    chk("t4_rd_req", {31'd0, rd_req_o}, 32'd1);
    recv_byte(1'b0, d); chk("t4_rd0", {24'd0, d}, 32'h5D);
    stop_cond();
    chk("t4_starts", start_cnt - s_start, 32'd2);
    exp_q.push_back(8'h11);
    check_writes("t4");

    // STOP in the middle of a write byte.
    snap();
    start_cond();
    send_byte(8'h44, ack); chk("t5_addr_ack", {31'd0, ack}, 32'd1);
    xfer_bit(1'b1, ack); xfer_bit(1'b0, ack); xfer_bit(1'b1, ack);
    stop_cond();
    check_writes("t5");
    chk("t5_state_idle", {28'd0, state_o}, 32'd0);
    chk("t5_sda_o", {31'd0, sda_o}, 32'd1);

    // Random transactions against the byte-level model.
    for (int t = 0; t < 8; t++) begin
      logic [6:0] addr;
      logic       rw;
      logic       match;
      int         n;
      logic [7:0] bytes[3];
      addr  = ($urandom_range(0, 2) != 0) ? SLAVE_ADDR : (SLAVE_ADDR ^ 7'($urandom_range(1, 127)));
      rw    = 1'($urandom_range(0, 1));
      n     = $urandom_range(1, 3);
      match = (addr == SLAVE_ADDR);
      for (int k = 0; k < 3; k++) bytes[k] = 8'($urandom);
      snap();
      start_cond();
      send_byte({addr, rw}, ack);
      chk("rnd_addr_ack", {31'd0, ack}, {31'd0, match});
      if (!rw) begin
        for (int k = 0; k < n; k++) begin
          send_byte(bytes[k], ack);
          chk("rnd_wr_ack", {31'd0, ack}, {31'd0, match});
          if (match) exp_q.push_back(bytes[k]);
        end
      end else if (match) begin
        for (int k = 0; k < n; k++) begin
          rd_mem[rd_wr_idx % 64] = bytes[k];
          rd_wr_idx++;
        end
        for (int k = 0; k < n; k++) begin
          recv_byte(k < n - 1, d);
          chk("rnd_rd_data", {24'd0, d}, {24'd0, bytes[k]});
        end
      end
      stop_cond();
      tick(4);
      check_writes("rnd");
      chk("rnd_nack", nack_cnt - s_nack, {31'd0, (rw && match)});
      chk("rnd_busy_end", {31'd0, busy_o}, 32'd0);
    end

    // Reset while the target is stretching SCL for read data.
    resp_en = 1'b0;
    start_cond();
    send_byte(8'h45, ack); chk("t6_addr_ack", {31'd0, ack}, 32'd1);
    m_sda = 1'b1;
    tick(H);
    m_scl = 1'b1;
    tick(30);
    chk("t6_stretching", {31'd0, scl_o}, 32'd0);
    chk("t6_rd_req_hi", {31'd0, rd_req_o}, 32'd1);
    rst_i = 1'b1;
    tick(1);
    chk("t6_scl_o", {31'd0, scl_o}, 32'd1);
    chk("t6_sda_o", {31'd0, sda_o}, 32'd1);
    chk("t6_rd_req", {31'd0, rd_req_o}, 32'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    tick(2);
    rst_i = 1'b0;
    tick(6);
    resp_en = 1'b1;

    // The target still works after the reset.
    snap();
    start_cond();
    send_byte(8'h44, ack); chk("t7_addr_ack", {31'd0, ack}, 32'd1);
    send_byte(8'h5A, ack); chk("t7_d0_ack", {31'd0, ack}, 32'd1);
    stop_cond();
    exp_q.push_back(8'h5A);
    check_writes("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
